// File: rtl/ram64_fifo_ctrl.sv
// Circular FIFO controller in front of a 64x16 single-port RAM.
// One RAM access per cycle: pop wins over push; read data returns two cycles after the request.
`timescale 1ns/1ps
module ram64_fifo_ctrl #(
  parameter int DW       = 16,
  parameter int AW       = 6,
  parameter int AF_LEVEL = 56
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  input  logic          flush,
  output logic          push_ack,
  output logic          pop_ack,
  output logic [DW-1:0] pop_data,
  output logic          pop_valid,
  output logic          full,
  output logic          empty,
  output logic          almost_full,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic          underflow,
  output logic [AW-1:0] ram_add,
  output logic [DW-1:0] ram_d_in,
  output logic          ram_w,
  output logic          ram_r,
  output logic          ram_en,
  input  logic [DW-1:0] ram_d_out
);

  localparam int DEPTH = 1 << AW;

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          rd_pend;

  assign empty       = (count == '0);
  assign full        = (count == (AW+1)'(DEPTH));
  assign almost_full = (count >= (AW+1)'(AF_LEVEL));

  assign pop_ack  = pop & ~empty & ~flush;
  assign push_ack = push & ~full & ~flush & ~pop_ack;

  assign ram_en   = pop_ack | push_ack;
  assign ram_r    = pop_ack;
  assign ram_w    = push_ack;
  assign ram_add  = pop_ack ? rd_ptr : (push_ack ? wr_ptr : '0);
  assign ram_d_in = push_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      rd_pend   <= 1'b0;
      pop_data  <= '0;
      pop_valid <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      // A read issued last cycle completes even across a flush.
      pop_valid <= rd_pend;
      if (rd_pend) pop_data <= ram_d_out;
      rd_pend <= pop_ack;

      if (push && full) overflow <= 1'b1;
      if (pop && empty) underflow <= 1'b1;

      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else if (pop_ack) begin
        rd_ptr <= rd_ptr + AW'(1);
        count  <= count - (AW+1)'(1);
      end else if (push_ack) begin
        wr_ptr <= wr_ptr + AW'(1);
        count  <= count + (AW+1)'(1);
      end
    end
  end

endmodule

// File: doc/ram64_fifo_ctrl.md
Name: ram64_fifo_ctrl

Overview:
- Circular-FIFO controller placed directly upstream of the 64x16 single-port RAM (ram64).
- Accepts push/pop requests from a producer and a consumer.
- Generates the RAM's address, data-in, w, r and en strobes, and returns read data with a valid flag.
- Turns the raw RAM into a 64-deep, 16-bit FIFO with full/empty/count status and one RAM access per cycle.

Parameters:
DW, 16, data width; matches RAM word width
AW, 6, address width; depth = 2**AW = 64
AF_LEVEL, 56, almost_full asserts when count >= AF_LEVEL

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
push  input  1  producer requests write of push_data
push_data  input  DW  word to enqueue
pop  input  1  consumer requests one word
flush  input  1  synchronous empty of FIFO (pointers/count cleared, RAM untouched)
push_ack  output  1  combinational; push accepted this cycle
pop_ack  output  1  combinational; pop accepted this cycle
pop_data  output  DW  registered read word
pop_valid  output  1  registered; pop_data valid this cycle
full  output  1  count == 64
empty  output  1  count == 0
almost_full  output  1  count >= AF_LEVEL
count  output  AW+1  words stored, 0..64
overflow  output  1  sticky: push while full
underflow  output  1  sticky: pop while empty
ram_add  output  AW  RAM address
ram_d_in  output  DW  RAM write data (= push_data)
ram_w  output  1  RAM write strobe
ram_r  output  1  RAM read strobe
ram_en  output  1  RAM enable
ram_d_out  input  DW  RAM read data

Behaviour:
- Reset (rst high at rising edge): wr_ptr=rd_ptr=0, count=0, pop_data=0, pop_valid=0, overflow=0, underflow=0, rd_pend=0. Status outputs then read empty=1, full=0, almost_full=0. rst overrides flush, push and pop; in-flight read is discarded and pop_valid stays 0 next cycle.
- RAM contract: RAM samples ram_add/ram_d_in/ram_w/ram_r/ram_en on the rising edge. Read data is presented on ram_d_out after that edge and held until the next enabled access.
- Arbitration, one RAM access per cycle:
  - pop_ack = pop & !empty & !flush.
  - push_ack = push & !full & !flush & !pop_ack. Pop has priority; a simultaneous push is stalled and not acked, and the producer holds push/push_data.
- RAM drive (combinational):
  - pop_ack: ram_en=1, ram_r=1, ram_w=0, ram_add=rd_ptr.
  - push_ack: ram_en=1, ram_w=1, ram_r=0, ram_add=wr_ptr.
  - Otherwise ram_en=ram_w=ram_r=0, ram_add=0.
  - ram_d_in = push_data always.
- Pointer/count update at edge:
  - push_ack: wr_ptr+1 mod 64, count+1.
  - pop_ack: rd_ptr+1 mod 64, count-1.
  - Pointers wrap 63->0 silently.
- Read latency:
  - Pop acked in cycle N sets rd_pend at edge N, with the RAM read occurring at the same edge.
  - At edge N+1, pop_data <= ram_d_out and pop_valid <= rd_pend.
  - pop_valid is therefore high in cycle N+2 (2 cycles after request), for exactly one cycle per acked pop.
  - Back-to-back pops give back-to-back pop_valid, in order.
- Full/empty boundaries:
  - push at count=64 is not acked, nothing written, overflow<=1.
  - pop at count=0 is not acked, no RAM access, underflow<=1.
  - push at count=0 with simultaneous pop: pop not acked (empty), push acked.
  - Sticky flags are cleared only by rst.
- flush: at edge, wr_ptr=rd_ptr=0, count=0, no RAM access that cycle. A read already pending still completes (pop_valid next cycle).
- Data written at edge N is readable by a pop acked in cycle N+1 or later.

Test Plan:
- Reset then idle 3 cycles -> empty=1, count=0, pop_valid=0, ram_en=0, overflow=underflow=0.
- Push 1..8 on 8 consecutive cycles, then pop 8 consecutive cycles -> ram_add 0..7 with ram_w=1 on pushes; pop_data 1..8 in order, pop_valid 2 cycles after each pop_ack; empty=1 at end.
- Push 64 words (value = index+100) -> full=1, count=64, almost_full set when count reaches 56. 65th push -> push_ack=0, overflow=1. Pop all -> data 100..163 in order.
- Wrap test: push 60, pop 60, push 10 (values 0xA0..0xA9) -> writes at ram_add 60..63,0..5; pops return 0xA0..0xA9.
- Simultaneous push+pop at count=5 -> pop_ack=1, push_ack=0, count=4. Held push acked next cycle, count=5. Pop at count=0 -> underflow=1, ram_en=0.
- rst asserted the cycle after a pop_ack -> pop_valid stays 0, count=0, empty=1. flush at count=20 -> count=0 next cycle, no RAM strobe that cycle.
